// File: rtl/lamp_alarm_sequencer.sv
// Synchronises and debounces the active-low ok/alert/danger flags and runs the severity FSM
// driving the panel lamps, buzzer and the saturating danger-entry counter.
module lamp_alarm_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 4,
    parameter int BLINK_HALF  = 8,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ok,
    input  logic             alert,
    input  logic             danger,
    input  logic             ack,
    output logic             lamp_green,
    output logic             lamp_amber,
    output logic             lamp_red,
    output logic             buzzer,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] danger_count
);

    localparam int DEB_W   = $clog2(DEBOUNCE + 1);
    localparam int BLINK_W = $clog2(2 * BLINK_HALF);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        NORMAL  = 3'd1,
        ALERT   = 3'd2,
        DANGER  = 3'd3,
        LATCHED = 3'd4
    } state_t;

    logic [2:0]             raw;
    logic [SYNC_STAGES-1:0] sync_q  [3];
    logic [DEB_W-1:0]       deb_cnt [3];
    logic [2:0]             filt;

    state_t               state_q, state_n, sev;
    logic                 mute, mute_n;
    logic [CNT_W-1:0]     count_n;
    logic [BLINK_W-1:0]   blink, blink_n;

    // Flag order inside the vectors: bit 0 = ok, bit 1 = alert, bit 2 = danger.
    assign raw = {danger, alert, ok};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                sync_q[i]  <= '1;
                deb_cnt[i] <= '0;
            end
            filt <= '1;
        end else begin
            for (int i = 0; i < 3; i++) begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], raw[i]};
                if (sync_q[i][SYNC_STAGES-1] != filt[i]) begin
                    if (deb_cnt[i] == DEB_W'(DEBOUNCE - 1)) begin
                        filt[i]    <= sync_q[i][SYNC_STAGES-1];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    always_comb begin
        if (!filt[2])      sev = DANGER;
        else if (!filt[1]) sev = ALERT;
        else if (!filt[0]) sev = NORMAL;
        else               sev = IDLE;
    end

    // Mute only ever matters inside DANGER; it is cleared on every fresh entry.
    always_comb begin
        state_n = state_q;
        mute_n  = mute;
        count_n = danger_count;
        unique case (state_q)
            IDLE, NORMAL, ALERT: state_n = sev;
            DANGER: begin
                if (ack) mute_n = 1'b1;
                if (filt[2]) state_n = mute ? sev : LATCHED;
            end
            LATCHED: begin
                if (!filt[2])  state_n = DANGER;
                else if (ack)  state_n = sev;
            end
            default: state_n = IDLE;
        endcase
        if (state_n == DANGER && state_q != DANGER) begin
            mute_n = 1'b0;
            if (danger_count != '1) count_n = danger_count + CNT_W'(1);
        end
        if (state_n != state_q || blink == BLINK_W'(2 * BLINK_HALF - 1))
            blink_n = '0;
        else
            blink_n = blink + BLINK_W'(1);
    end

    // Outputs are decoded from next-state values so they line up with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            mute         <= 1'b0;
            danger_count <= '0;
            blink        <= '0;
            lamp_green   <= 1'b0;
            lamp_amber   <= 1'b0;
            lamp_red     <= 1'b0;
            buzzer       <= 1'b0;
        end else begin
            state_q      <= state_n;
            mute         <= mute_n;
            danger_count <= count_n;
            blink        <= blink_n;
            lamp_green   <= (state_n == NORMAL);
            lamp_amber   <= (state_n == ALERT) && (blink_n < BLINK_W'(BLINK_HALF));
            lamp_red     <= (state_n == DANGER) ||
                            ((state_n == LATCHED) && (blink_n < BLINK_W'(BLINK_HALF)));
            buzzer       <= (state_n == DANGER) && !mute_n;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_lamp_alarm_sequencer.sv
// Directed bench for lamp_alarm_sequencer: latency, debounce, blink, ack/latch handling and
// counter saturation, with hand-computed expectations (CNT_W=2, other parameters at defaults).
module tb_lamp_alarm_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ok, alert, danger, ack;
    logic       lamp_green, lamp_amber, lamp_red, buzzer;
    logic [2:0] state;
    logic [1:0] danger_count;

    int pass_cnt  = 0;
    int check_cnt = 0;

    lamp_alarm_sequencer #(
        .SYNC_STAGES(2),
        .DEBOUNCE   (4),
        .BLINK_HALF (8),
        .CNT_W      (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ok          (ok),
        .alert       (alert),
        .danger      (danger),
        .ack         (ack),
        .lamp_green  (lamp_green),
        .lamp_amber  (lamp_amber),
        .lamp_red    (lamp_red),
        .buzzer      (buzzer),
        .state       (state),
        .danger_count(danger_count)
    );

    always #5 clk = ~clk;

    // Advance n rising edges and land 1 ns after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        ok     = 1'b1;
        alert  = 1'b1;
        danger = 1'b1;
        ack    = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic test_reset();
        do_reset();
        check_cnt++;
        if (state !== 3'd0) $display("[TB] FAIL reset_state got %0d want 0", state);
        else pass_cnt++;
        check_cnt++;
        if ({lamp_green, lamp_amber, lamp_red, buzzer} !== 4'b0000)
            $display("[TB] FAIL reset_outputs got %b want 0000",
                     {lamp_green, lamp_amber, lamp_red, buzzer});
        else pass_cnt++;
        check_cnt++;
        if (danger_count !== 2'd0) $display("[TB] FAIL reset_count got %0d want 0", danger_count);
        else pass_cnt++;
    endtask

    task automatic test_ok_latency();
        ok = 1'b0;
        step(6);
        check_cnt++;
        if (lamp_green !== 1'b0) $display("[TB] FAIL green_edge6 got %b want 0", lamp_green);
        else pass_cnt++;
        step(1);
        check_cnt++;
        if (lamp_green !== 1'b1) $display("[TB] FAIL green_edge7 got %b want 1", lamp_green);
        else pass_cnt++;
        check_cnt++;
        if (state !== 3'd1) $display("[TB] FAIL normal_state got %0d want 1", state);
        else pass_cnt++;
    endtask

    task automatic test_alert_blink();
        alert = 1'b0;
        step(3);
        alert = 1'b1;
        step(12);
        check_cnt++;
        if (state !== 3'd1) $display("[TB] FAIL alert_glitch got %0d want 1", state);
        else pass_cnt++;
        alert = 1'b0;
        step(6);
        check_cnt++;
        if (state !== 3'd1) $display("[TB] FAIL alert_edge6 got %0d want 1", state);
        else pass_cnt++;
        step(1);
        check_cnt++;
        if (state !== 3'd2 || lamp_amber !== 1'b1 || lamp_green !== 1'b0)
            $display("[TB] FAIL alert_entry got state=%0d amber=%b green=%b want 2 1 0",
                     state, lamp_amber, lamp_green);
        else pass_cnt++;
        step(7);
        check_cnt++;
        if (lamp_amber !== 1'b1) $display("[TB] FAIL amber_last_on got %b want 1", lamp_amber);
        else pass_cnt++;
        step(1);
        check_cnt++;
        if (lamp_amber !== 1'b0) $display("[TB] FAIL amber_first_off got %b want 0", lamp_amber);
        else pass_cnt++;
        step(7);
        check_cnt++;
        if (lamp_amber !== 1'b0) $display("[TB] FAIL amber_last_off got %b want 0", lamp_amber);
        else pass_cnt++;
        step(1);
        check_cnt++;
        if (lamp_amber !== 1'b1) $display("[TB] FAIL amber_wrap got %b want 1", lamp_amber);
        else pass_cnt++;
    endtask

    task automatic test_danger_ack();
        danger = 1'b0;
        step(6);
        check_cnt++;
        if (state !== 3'd2) $display("[TB] FAIL danger_edge6 got %0d want 2", state);
        else pass_cnt++;
        step(1);
        check_cnt++;
        if (state !== 3'd3 || lamp_red !== 1'b1 || buzzer !== 1'b1 || lamp_amber !== 1'b0)
            $display("[TB] FAIL danger_entry got state=%0d red=%b buz=%b amber=%b want 3 1 1 0",
                     state, lamp_red, buzzer, lamp_amber);
        else pass_cnt++;
        check_cnt++;
        if (danger_count !== 2'd1) $display("[TB] FAIL danger_count1 got %0d want 1", danger_count);
        else pass_cnt++;
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        check_cnt++;
        if (buzzer !== 1'b0 || lamp_red !== 1'b1 || state !== 3'd3)
            $display("[TB] FAIL ack_mute got buz=%b red=%b state=%0d want 0 1 3",
                     buzzer, lamp_red, state);
        else pass_cnt++;
        danger = 1'b1;
        step(6);
        check_cnt++;
        if (state !== 3'd3) $display("[TB] FAIL release_edge6 got %0d want 3", state);
        else pass_cnt++;
        step(1);
        check_cnt++;
        if (state !== 3'd2 || lamp_red !== 1'b0)
            $display("[TB] FAIL muted_release got state=%0d red=%b want 2 0", state, lamp_red);
        else pass_cnt++;
    endtask

    task automatic test_latched();
        danger = 1'b0;
        step(7);
        check_cnt++;
        if (state !== 3'd3 || buzzer !== 1'b1 || danger_count !== 2'd2)
            $display("[TB] FAIL danger2 got state=%0d buz=%b cnt=%0d want 3 1 2",
                     state, buzzer, danger_count);
        else pass_cnt++;
        danger = 1'b1;
        step(7);
        check_cnt++;
        if (state !== 3'd4 || lamp_red !== 1'b1 || buzzer !== 1'b0)
            $display("[TB] FAIL latched_entry got state=%0d red=%b buz=%b want 4 1 0",
                     state, lamp_red, buzzer);
        else pass_cnt++;
        step(8);
        check_cnt++;
        if (lamp_red !== 1'b0 || state !== 3'd4)
            $display("[TB] FAIL latched_blink_off got red=%b state=%0d want 0 4", lamp_red, state);
        else pass_cnt++;
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        check_cnt++;
        if (state !== 3'd2 || danger_count !== 2'd2 || lamp_amber !== 1'b1)
            $display("[TB] FAIL latched_ack got state=%0d cnt=%0d amber=%b want 2 2 1",
                     state, danger_count, lamp_amber);
        else pass_cnt++;
    endtask

    task automatic test_latched_reassert();
        do_reset();
        danger = 1'b0;
        step(7);
        danger = 1'b1;
        step(7);
        check_cnt++;
        if (state !== 3'd4 || danger_count !== 2'd1)
            $display("[TB] FAIL reassert_setup got state=%0d cnt=%0d want 4 1", state, danger_count);
        else pass_cnt++;
        danger = 1'b0;
        step(6);
        ack = 1'b1;
        step(1);
        check_cnt++;
        if (state !== 3'd3 || danger_count !== 2'd2 || buzzer !== 1'b1)
            $display("[TB] FAIL reassert_ack got state=%0d cnt=%0d buz=%b want 3 2 1",
                     state, danger_count, buzzer);
        else pass_cnt++;
        step(1);
        ack = 1'b0;
        check_cnt++;
        if (buzzer !== 1'b0 || state !== 3'd3)
            $display("[TB] FAIL held_ack_mute got buz=%b state=%0d want 0 3", buzzer, state);
        else pass_cnt++;
    endtask

    task automatic test_saturation();
        logic [1:0] exp_cnt [5];
        exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            danger = 1'b0;
            step(7);
            check_cnt++;
            if (state !== 3'd3 || danger_count !== exp_cnt[i])
                $display("[TB] FAIL sat_entry%0d got state=%0d cnt=%0d want 3 %0d",
                         i, state, danger_count, exp_cnt[i]);
            else pass_cnt++;
            ack = 1'b1;
            step(1);
            ack = 1'b0;
            danger = 1'b1;
            step(7);
            check_cnt++;
            if (state !== 3'd0) $display("[TB] FAIL sat_idle%0d got %0d want 0", i, state);
            else pass_cnt++;
        end
        danger = 1'b0;
        step(7);
        #3;
        rst_n = 1'b0;
        #1;
        check_cnt++;
        if (state !== 3'd0 || danger_count !== 2'd0 ||
            {lamp_green, lamp_amber, lamp_red, buzzer} !== 4'b0000)
            $display("[TB] FAIL async_reset got state=%0d cnt=%0d outs=%b want 0 0 0000",
                     state, danger_count, {lamp_green, lamp_amber, lamp_red, buzzer});
        else pass_cnt++;
        danger = 1'b1;
        step(1);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_ok_latency();
        test_alert_blink();
        test_danger_ack();
        test_latched();
        test_latched_reassert();
        test_saturation();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
